// File: rtl/dcache_mem_xfer_if.sv
// ---------------------------------------------------------------------------
// dcache_mem_xfer_if
//   Bundle of every signal between the line-transfer engine and its two
//   neighbours: the cache controller (request side) and the memory port
//   (beat side).
//
//   Parameters
//     LINE_SIZE : cache line size in bytes
//     XLEN      : memory data / address width in bits
//
//   Modports
//     slave  : the transfer engine. It serves cache requests and drives
//              the memory beat bus.
//     master : the environment, i.e. the cache controller together with
//              the memory model. It issues requests and answers beats.
//
//   Signals
//     req_valid / req_ready : request handshake
//     req_wb, req_fill      : request carries a writeback and/or a fill
//     wb_addr, fill_addr    : victim / missed line addresses
//     wb_line               : victim line data, word k at [k*XLEN +: XLEN]
//     fill_line             : assembled fill data, same word packing
//     done                  : one-cycle completion pulse
//     mem_valid / mem_ready : beat handshake
//     mem_we                : 1 = write beat, 0 = read beat
//     mem_addr, mem_wdata   : beat byte address and write data
//     mem_rdata             : read data, valid on an accepted read beat
// ---------------------------------------------------------------------------
interface dcache_mem_xfer_if #(
  parameter int LINE_SIZE = 32,
  parameter int XLEN      = 32
);

  // Cache request side
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_wb;
  logic                   req_fill;
  logic [XLEN-1:0]        wb_addr;
  logic [XLEN-1:0]        fill_addr;
  logic [LINE_SIZE*8-1:0] wb_line;
  logic [LINE_SIZE*8-1:0] fill_line;
  logic                   done;

  // Memory beat side
  logic                   mem_valid;
  logic                   mem_ready;
  logic                   mem_we;
  logic [XLEN-1:0]        mem_addr;
  logic [XLEN-1:0]        mem_wdata;
  logic [XLEN-1:0]        mem_rdata;

  modport slave (
    input  req_valid, req_wb, req_fill, wb_addr, fill_addr, wb_line,
    input  mem_ready, mem_rdata,
    output req_ready, fill_line, done,
    output mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wb, req_fill, wb_addr, fill_addr, wb_line,
    output mem_ready, mem_rdata,
    input  req_ready, fill_line, done,
    input  mem_valid, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_mem_xfer.sv
// ---------------------------------------------------------------------------
// dcache_mem_xfer
//   Moves whole cache lines between the data cache and a word-wide memory
//   port. A single request may write back a dirty victim line, fill a
//   missed line, both (writeback first), or neither. Each line is moved as
//   BEATS consecutive word beats on a valid/ready memory bus; fill beats are
//   assembled into the fill_line register, which keeps its value until the
//   next fill overwrites it.
//
//   Parameters
//     LINE_SIZE : line size in bytes (default 32)
//     XLEN      : memory data and address width in bits (default 32)
//
//   Ports
//     clk   : clock, all state changes on the rising edge
//     reset : asynchronous, active-low reset (0 = in reset)
//     bus   : dcache_mem_xfer_if.slave, request and memory beat signals
//
//   Timing with mem_ready held high, request accepted on edge T:
//     no-op done at T+1, fill-only at T+1+BEATS, wb+fill at T+1+2*BEATS.
// ---------------------------------------------------------------------------
module dcache_mem_xfer #(
  parameter int LINE_SIZE = 32,
  parameter int XLEN      = 32
) (
  input  logic             clk,
  input  logic             reset,
  dcache_mem_xfer_if.slave bus
);

  localparam int BEATS     = LINE_SIZE / (XLEN / 8);
  localparam int OFS_SIZE  = $clog2(LINE_SIZE);
  localparam int BEAT_BITS = $clog2(BEATS);
  // Byte-within-word bits: the zero padding below the beat index.
  localparam int BYTE_BITS = $clog2(XLEN / 8);
  // Keep the counter at least one bit wide so a one-beat line still builds.
  localparam int CNT_W     = (BEAT_BITS > 0) ? BEAT_BITS : 1;
  localparam int TAG_W     = XLEN - OFS_SIZE;
  localparam int LINE_W    = LINE_SIZE * 8;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    beat_q,      beat_d;
  // Only the line-number part of each address is kept; the offset bits of
  // the request are ignored and regenerated from the beat counter.
  logic [TAG_W-1:0]    wb_tag_q,    wb_tag_d;
  logic [TAG_W-1:0]    fill_tag_q,  fill_tag_d;
  logic [LINE_W-1:0]   wb_line_q,   wb_line_d;
  // Remembers whether a fill follows the writeback phase.
  logic                fill_pend_q, fill_pend_d;

  // -------------------------------------------------------------------------
  // Combinational outputs
  // -------------------------------------------------------------------------
  logic                req_ready;
  logic                done;
  logic                mem_valid;
  logic                mem_we;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  // Write strobe into the fill line for the current beat.
  logic                fill_we;

  logic [XLEN-1:0]     beat_ofs;
  logic [XLEN-1:0]     wb_word [BEATS];
  logic [LINE_W-1:0]   fill_line_w;

  // Byte offset of the current beat within the line.
  assign beat_ofs = XLEN'(beat_q) << BYTE_BITS;

  genvar gi;

  // Victim line viewed as an array of words, indexed by the beat counter.
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_wb_word
      assign wb_word[gi] = wb_line_q[gi*XLEN +: XLEN];
    end
  endgenerate

  // Fill line storage: one register per word, each loaded only by the read
  // beat that carries its index. Words not yet rewritten by a fill keep
  // their previous contents.
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_fill_word
      logic [XLEN-1:0] word_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          word_q <= '0;
        end else if (fill_we && (beat_q == CNT_W'(gi))) begin
          word_q <= bus.mem_rdata;
        end
      end

      assign fill_line_w[gi*XLEN +: XLEN] = word_q;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wb_tag_d    = wb_tag_q;
    fill_tag_d  = fill_tag_q;
    wb_line_d   = wb_line_q;
    fill_pend_d = fill_pend_q;

    req_ready   = 1'b0;
    done        = 1'b0;
    mem_valid   = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          // Everything the transfer needs is captured here so that the
          // cache may change its request lines freely afterwards.
          wb_tag_d    = bus.wb_addr[XLEN-1:OFS_SIZE];
          fill_tag_d  = bus.fill_addr[XLEN-1:OFS_SIZE];
          wb_line_d   = bus.wb_line;
          fill_pend_d = bus.req_fill;
          beat_d      = '0;
          if (bus.req_wb) begin
            state_d = WB;
          end else if (bus.req_fill) begin
            state_d = FILL;
          end else begin
            state_d = DONE;
          end
        end
      end

      WB: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wb_tag_q, {OFS_SIZE{1'b0}}} | beat_ofs;
        mem_wdata = wb_word[beat_q];
        // Address and data come straight from registers, so they hold
        // unchanged for as long as memory stalls the beat.
        if (bus.mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = fill_pend_q ? FILL : DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      FILL: begin
        mem_valid = 1'b1;
        mem_addr  = {fill_tag_q, {OFS_SIZE{1'b0}}} | beat_ofs;
        if (bus.mem_ready) begin
          fill_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wb_tag_q    <= '0;
      fill_tag_q  <= '0;
      wb_line_q   <= '0;
      fill_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wb_tag_q    <= wb_tag_d;
      fill_tag_q  <= fill_tag_d;
      wb_line_q   <= wb_line_d;
      fill_pend_q <= fill_pend_d;
    end
  end

  // -------------------------------------------------------------------------
  // Drive the bus
  // -------------------------------------------------------------------------
  assign bus.req_ready = req_ready;
  assign bus.done      = done;
  assign bus.mem_valid = mem_valid;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.fill_line = fill_line_w;

endmodule

// File: tb/tb_dcache_mem_xfer.sv
// ---------------------------------------------------------------------------
// tb_dcache_mem_xfer
//   Self-checking bench for dcache_mem_xfer. For each request the bench
//   lists the beats it expects (direction, address, write data) from the
//   line addresses and line contents, plays a memory that answers with
//   chosen ready patterns and read data, and compares every cycle against
//   that list, the expected completion cycle and the expected fill line.
// ---------------------------------------------------------------------------
module tb_dcache_mem_xfer;

  localparam int LS    = 32;
  localparam int XL    = 32;
  localparam int BEATS = LS / (XL / 8);
  localparam int LW    = LS * 8;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  // Fill line contents the bench expects the design to present.
  logic [LW-1:0] fill_model;

  dcache_mem_xfer_if #(.LINE_SIZE(LS), .XLEN(XL)) bus ();

  dcache_mem_xfer #(.LINE_SIZE(LS), .XLEN(XL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*XL +: XL] = $urandom;
    return l;
  endfunction

  // Present a request and let the next rising edge accept it.
  task automatic issue(input bit do_wb, input bit do_fill, input logic [XL-1:0] wa,
                       input logic [XL-1:0] fa, input logic [LW-1:0] line);
    bus.req_valid = 1'b1;
    bus.req_wb    = do_wb;
    bus.req_fill  = do_fill;
    bus.wb_addr   = wa;
    bus.fill_addr = fa;
    bus.wb_line   = line;
    bus.mem_ready = 1'(($urandom));
    check("req_ready_idle", bus.req_ready, 1);
    @(posedge clk);
  endtask

  // rmode: 0 = always ready, 1 = random ready, 2 = three stalls on fill beat 4
  // pat  : fill read data is 0xA0 + beat instead of random
  // exp_done: required completion cycle after accept, or -1 to skip
  task automatic run_xfer(input bit do_wb, input bit do_fill, input logic [XL-1:0] wa,
                          input logic [XL-1:0] fa, input logic [LW-1:0] line,
                          input int rmode, input bit pat, input int exp_done);
    logic [XL-1:0] q_addr[$];
    logic          q_we[$];
    logic [XL-1:0] q_wd[$];
    logic [XL-1:0] wbase, fbase;
    int  nbeats, stalls, idx, nfill, stall_left;
    bit  r;

    wbase = wa & ~(XL'(LS - 1));
    fbase = fa & ~(XL'(LS - 1));
    if (do_wb) begin
      for (int k = 0; k < BEATS; k++) begin
        q_we.push_back(1'b1);
        q_addr.push_back(wbase + XL'(4 * k));
        q_wd.push_back(line[k*XL +: XL]);
      end
    end
    if (do_fill) begin
      for (int k = 0; k < BEATS; k++) begin
        q_we.push_back(1'b0);
        q_addr.push_back(fbase + XL'(4 * k));
        q_wd.push_back('0);
      end
    end
    nbeats     = q_addr.size();
    stalls     = 0;
    idx        = 0;
    nfill      = 0;
    stall_left = 3;

    issue(do_wb, do_fill, wa, fa, line);

    forever begin
      @(negedge clk);
      idx++;
      if (idx > 200) begin
        check("timeout", idx, 0);
        break;
      end
      if (q_addr.size() != 0) begin
        check("mem_valid", bus.mem_valid, 1);
        check("mem_we", bus.mem_we, q_we[0]);
        check("mem_addr", bus.mem_addr, q_addr[0]);
        check("mem_wdata", bus.mem_wdata, q_wd[0]);
        check("busy_done", bus.done, 0);
        check("busy_req_ready", bus.req_ready, 0);
        case (rmode)
          0:       r = 1'b1;
          1:       r = ($urandom_range(0, 3) != 0);
          default: begin
            r = !(!q_we[0] && nfill == 4 && stall_left > 0);
            if (!r) stall_left--;
          end
        endcase
        bus.mem_ready = r;
        bus.mem_rdata = (pat && !q_we[0]) ? (XL'(32'hA0) + XL'(nfill)) : XL'($urandom);
        if (r) begin
          if (!q_we[0]) begin
            fill_model[nfill*XL +: XL] = bus.mem_rdata;
            nfill++;
          end
          void'(q_we.pop_front());
          void'(q_addr.pop_front());
          void'(q_wd.pop_front());
        end else begin
          stalls++;
        end
        // While busy, wave a different request at the block; it must be ignored.
        if (q_addr.size() != 0) begin
          bus.req_valid = 1'b1;
          bus.req_wb    = 1'(($urandom));
          bus.req_fill  = 1'(($urandom));
          bus.wb_addr   = $urandom;
          bus.fill_addr = $urandom;
          bus.wb_line   = rand_line();
        end else begin
          bus.req_valid = 1'b0;
        end
      end else begin
        check("done_mem_valid", bus.mem_valid, 0);
        check("done_mem_wdata", bus.mem_wdata, 0);
        check("done_pulse", bus.done, 1);
        check("done_cycle", idx, 1 + nbeats + stalls);
        if (exp_done >= 0) check("done_cycle_spec", idx, exp_done);
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'(($urandom));
        break;
      end
    end

    @(negedge clk);
    check("post_done", bus.done, 0);
    check("post_req_ready", bus.req_ready, 1);
    check("post_mem_valid", bus.mem_valid, 0);
    check("fill_line", bus.fill_line, fill_model);
    $display("xfer wb=%0b fill=%0b wb_addr=%08h fill_addr=%08h mode=%0d cycles=%0d stalls=%0d",
             do_wb, do_fill, wa, fa, rmode, idx, stalls);
  endtask

  initial begin
    logic [LW-1:0]  line;
    logic [XL-1:0]  fa;
    logic [XL-1:0]  fbase;

    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wb    = 1'b0;
    bus.req_fill  = 1'b0;
    bus.wb_addr   = '0;
    bus.fill_addr = '0;
    bus.wb_line   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    fill_model    = '0;

    // Reset values, visible before any clock edge.
    #3;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_fill_line", bus.fill_line, 0);
    $display("reset check done");

    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Fill-only with offset bits set in the address and patterned read data.
    run_xfer(1'b0, 1'b1, 32'h0, 32'h0000_1047, '0, 0, 1'b1, 1 + BEATS);
    for (int k = 0; k < BEATS; k++) begin
      check("fill_word_pattern", bus.fill_line[k*XL +: XL], 32'hA0 + k);
    end

    // Writeback then fill.
    for (int k = 0; k < BEATS; k++) line[k*XL +: XL] = 32'h100 + k;
    run_xfer(1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000, line, 0, 1'b0, 1 + 2 * BEATS);

    // Memory stalls fill beat 4 for three cycles.
    run_xfer(1'b0, 1'b1, 32'h0, 32'h0000_1040, '0, 2, 1'b1, 1 + BEATS + 3);

    // No-op request.
    run_xfer(1'b0, 1'b0, 32'h0000_4000, 32'h0000_5000, rand_line(), 0, 1'b0, 1);

    // Writeback only: fill line must be untouched.
    run_xfer(1'b1, 1'b0, 32'h0000_6013, 32'h0000_7000, rand_line(), 0, 1'b0, 1 + BEATS);

    // Reset in the middle of a fill, after three beats.
    fa    = 32'h0000_8020;
    fbase = fa & ~(XL'(LS - 1));
    issue(1'b0, 1'b1, 32'h0, fa, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_addr", bus.mem_addr, fbase + XL'(4 * k));
      bus.req_valid = 1'b0;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = $urandom;
    end
    @(negedge clk);
    check("abort_pending", bus.mem_valid, 1);
    bus.mem_ready = 1'b0;
    reset         = 1'b0;
    #1;
    check("abort_mem_valid", bus.mem_valid, 0);
    check("abort_mem_addr", bus.mem_addr, 0);
    check("abort_req_ready", bus.req_ready, 1);
    check("abort_done", bus.done, 0);
    check("abort_fill_line", bus.fill_line, 0);
    fill_model = '0;
    @(negedge clk);
    check("abort_hold_done", bus.done, 0);
    reset = 1'b1;
    @(negedge clk);
    check("release_req_ready", bus.req_ready, 1);
    check("release_done", bus.done, 0);
    check("release_fill_line", bus.fill_line, 0);
    $display("reset abort check done");

    // First request after reset restarts at beat 0.
    run_xfer(1'b0, 1'b1, 32'h0, 32'h0000_9000, '0, 0, 1'b1, 1 + BEATS);

    // Random requests with random memory backpressure.
    for (int t = 0; t < 16; t++) begin
      run_xfer(1'(($urandom)), 1'(($urandom)), $urandom, $urandom, rand_line(), 1, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
